seg_shift_ctrl: RTL and testbench
=================================

# seg_shift_ctrl

Serial frame controller for the seven-segment display path. It captures the 64-bit segment pattern produced by the segment mapping logic and shifts it out MSB-first to the board's chained serial-in shift registers. It generates the serial clock and data, and blanks the display while a frame is being shifted. It sits between the display-number/segment-map datapath and the board pins, and has one start/busy/done handshake toward the CPU-side display logic.

## Interface
- WIDTH, 64: frame length in bits; equals segment-map width.
- CLK_DIV, 2: seg_clk half-period in clk cycles; legal range ≥1.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to shift a frame; sampled each cycle.
- data  input  WIDTH  segment pattern; captured when a frame is accepted.
- busy  output  1  frame in progress (SHIFT or DONE state).
- done  output  1  one-cycle pulse when a frame completes.
- seg_clk  output  1  serial shift clock to the display shift registers.
- seg_sout  output  1  serial data; valid across each seg_clk rising edge.
- seg_pen  output  1  display enable; 1 lights the display.
- seg_clrn  output  1  active-low clear to the shift registers.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 or pending=1, capture data into shreg, clear pending, set bit counter = WIDTH-1 and phase counter = 0, then go to SHIFT.
- SHIFT:
  - seg_sout = shreg[WIDTH-1].
  - Each bit occupies 2*CLK_DIV cycles: seg_clk=0 for the first CLK_DIV cycles and 1 for the next CLK_DIV cycles.
  - At the end of the high phase, shreg shifts left by 1 and the bit counter decrements.
  - After bit 0 completes, go to DONE.
- DONE: held for 1 cycle; done=1, seg_clk=0, then return to IDLE.
- Pending: start=1 while in SHIFT or DONE sets pending. A pending request starts a new frame on the cycle after DONE (first IDLE cycle). Multiple starts collapse into one.
- data is sampled only at frame acceptance. Changes to data during a frame do not affect that frame.
- seg_pen: 0 from reset until the first DONE; 0 throughout SHIFT; 1 from DONE onward while idle.
- seg_clrn: 0 while rst is asserted; 1 on the first clk edge after rst deasserts. It is never driven low otherwise.
- Counter widths: phase $clog2(CLK_DIV) bits (min 1); bit counter $clog2(WIDTH) bits. No wrap is reachable.

## Timing
- Reset values: busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0; state=IDLE; pending=0; shreg=0.
- Let start be sampled in IDLE at edge 0:
  - SHIFT occupies cycles 1 to WIDTH*2*CLK_DIV.
  - DONE occupies cycle WIDTH*2*CLK_DIV+1.
  - Default parameters give 256 SHIFT cycles with DONE at cycle 257.
- The seg_clk rising edge for bit i (i=0 is the first bit, data[WIDTH-1]) falls at cycle 1+2*CLK_DIV*i+CLK_DIV. seg_sout is stable for CLK_DIV cycles on each side of that edge.
- busy=1 from cycle 1 through DONE inclusive. Back-to-back frames have exactly one IDLE cycle between them.
- An asynchronous reset mid-frame forces all reset values immediately, aborts the frame and drops pending.

## Configuration
- SEG_AUTO_REFRESH_EN defined:
  - The block keeps a WIDTH-bit copy of the last captured frame.
  - In IDLE, data differing from that copy is treated as start=1.
  - The copy resets to 0, so nonzero data after reset triggers a frame.
- SEG_AUTO_REFRESH_EN undefined: no copy register; frames start only via start or pending.

## Test plan
- Reset: hold rst=0 → all outputs 0. Release → seg_clrn=1 next edge; others stay 0, no seg_clk activity.
- Default params, data=64'h8000_0000_0000_0001, single start pulse → 64 seg_clk rises; sampled bits are 1, then 62 zeros, then 1. busy high cycles 1–257; done pulse at 257; seg_pen=1 from 257.
- start pulsed at cycle 100 of a frame with data changed to 64'hFFFF_0000_FFFF_0000 → current frame unchanged; second frame starts the cycle after DONE and shifts 64'hFFFF_0000_FFFF_0000.
- data toggled every cycle during SHIFT → shifted bits equal the value captured at acceptance.
- rst=0 at cycle 50 of a frame with start pending → outputs reset asynchronously; after release, no frame starts without a new start.
- SEG_AUTO_REFRESH_EN: set data=64'h1234 while idle with start=0 → frame shifts 64'h1234. Hold data constant → no further seg_clk edges.

Source files
------------

// File: rtl/seg_shift_ctrl.sv
// seg_shift_ctrl: serial frame controller for the seven-segment display path.
// Captures a WIDTH-bit segment pattern and shifts it MSB-first to chained
// serial-in shift registers. It generates seg_clk and seg_sout, and blanks the
// display (seg_pen=0) while a frame is in flight.
// Optional feature macro: SEG_AUTO_REFRESH_EN. When it is defined, the block
// starts a frame on its own whenever the idle data differs from the last frame.
module seg_shift_ctrl #(
  parameter int WIDTH   = 64,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             seg_clk,
  output logic             seg_sout,
  output logic             seg_pen,
  output logic             seg_clrn
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             pending;
  logic [WIDTH-1:0] shreg;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bitcnt;
  logic             accept;

`ifdef SEG_AUTO_REFRESH_EN
  logic [WIDTH-1:0] last;

  // copy of the last accepted frame; idle data differing from it acts as start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           last <= '0;
    else if (state == IDLE && accept)   last <= data;
  end

  assign accept = start | pending | (data != last);
`else
  assign accept = start | pending;
`endif

  // the shift register MSB is the serial line; it is zero whenever idle
  assign seg_sout = shreg[WIDTH-1];

  // clear to the shift registers is released on the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seg_clrn <= 1'b0;
    else      seg_clrn <= 1'b1;
  end

  // frame FSM: seg_clk doubles as the half-bit indicator inside SHIFT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      shreg   <= '0;
      phase   <= '0;
      bitcnt  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_clk <= 1'b0;
      seg_pen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= data;
            pending <= 1'b0;
            bitcnt  <= BIT_LAST;
            phase   <= '0;
            seg_clk <= 1'b0;
            busy    <= 1'b1;
            seg_pen <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (start) pending <= 1'b1;
          if (phase == PH_LAST) begin
            phase   <= '0;
            seg_clk <= ~seg_clk;
            // end of the high half: next bit, or finish after bit 0
            if (seg_clk) begin
              shreg <= shreg << 1;
              if (bitcnt == '0) begin
                state   <= DONE;
                done    <= 1'b1;
                seg_pen <= 1'b1;
              end else begin
                bitcnt <= bitcnt - 1'b1;
              end
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          if (start) pending <= 1'b1;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Testbench for seg_shift_ctrl: randomized frames checked cycle by cycle
// against a timeline model computed from the frame timing rules.
module tb_seg_shift_ctrl;
  localparam int W  = 64;
  localparam int CD = 2;
  localparam int T  = W * 2 * CD;
  localparam int N  = 1100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data = '0;
  logic busy, done, seg_clk, seg_sout, seg_pen, seg_clrn;

  int tests = 0;
  int fails = 0;

  // observed trace, indexed by cycle number after the accepting edge
  logic busy_tr[N], done_tr[N], clk_tr[N], sout_tr[N], pen_tr[N];
  // expected trace
  logic exp_busy[N], exp_done[N], exp_clk[N], exp_sout[N], exp_pen[N];
  bit   exp_chk[N];

  seg_shift_ctrl #(.WIDTH(W), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy), .done(done), .seg_clk(seg_clk), .seg_sout(seg_sout),
    .seg_pen(seg_pen), .seg_clrn(seg_clrn)
  );

  always #5 clk = ~clk;

  // reference timeline: frame 1 at cycles 1..T+1, optional frame 2 after one idle cycle
  task automatic model(input logic [W-1:0] d1, input bit two, input logic [W-1:0] d2);
    for (int c = 1; c < N; c++) begin
      int k;
      logic [W-1:0] dd;
      k = 0; dd = d1;
      if (c <= T + 1) k = c;
      else if (two && c >= T + 3 && c <= 2 * T + 3) begin k = c - (T + 2); dd = d2; end
      exp_chk[c] = 1'b0; exp_sout[c] = 1'b0;
      if (k == 0) begin
        exp_busy[c] = 0; exp_done[c] = 0; exp_clk[c] = 0; exp_pen[c] = 1;
      end else if (k <= T) begin
        exp_busy[c] = 1; exp_done[c] = 0; exp_pen[c] = 0;
        exp_clk[c]  = ((k - 1) % (2 * CD)) >= CD;
        exp_sout[c] = dd[W - 1 - (k - 1) / (2 * CD)];
        exp_chk[c]  = 1'b1;
      end else begin
        exp_busy[c] = 1; exp_done[c] = 1; exp_clk[c] = 0; exp_pen[c] = 1;
      end
    end
  endtask

  // present data+start so the next rising edge accepts the frame (edge 0)
  task automatic kick(input logic [W-1:0] d);
    @(negedge clk);
    data  = d;
    start = 1'b1;
  endtask

  // record outputs for cycles 1..ncyc; optional start burst at mid (3 cycles)
  // with new data, optional per-cycle data scrambling restored before the end
  task automatic observe(input int ncyc, input int mid, input logic [W-1:0] mid_data,
                         input bit toggle, input logic [W-1:0] hold);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      busy_tr[c] = busy; done_tr[c] = done; clk_tr[c] = seg_clk;
      sout_tr[c] = seg_sout; pen_tr[c] = seg_pen;
      start = (mid != 0) && (c >= mid) && (c < mid + 3);
      if (mid != 0 && c == mid) data = mid_data;
      if (toggle) data = (c < T - 1) ? {$urandom, $urandom} : hold;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, seg_clk, seg_sout, seg_pen, seg_clrn} !== 6'b0) begin
      fails++; $display("FAIL reset_hold got=%b exp=000000",
                        {busy, done, seg_clk, seg_sout, seg_pen, seg_clrn});
    end
    rst = 1'b1;
    #1;
    tests++;
    if (seg_clrn !== 1'b0) begin fails++; $display("FAIL clrn_before_edge got=%b exp=0", seg_clrn); end
    @(negedge clk);
    tests++;
    if ({busy, done, seg_clk, seg_sout, seg_pen, seg_clrn} !== 6'b000001) begin
      fails++; $display("FAIL reset_release got=%b exp=000001",
                        {busy, done, seg_clk, seg_sout, seg_pen, seg_clrn});
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if (seg_clk !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL reset_idle c=%0d seg_clk=%b busy=%b exp 0 0", c, seg_clk, busy);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [W-1:0] d, bits;
    int rises;
    d = 64'h8000_0000_0000_0001;
    model(d, 0, '0);
    kick(d);
    observe(T + 8, 0, '0, 0, '0);
    rises = 0; bits = '0;
    for (int c = 1; c <= T + 8; c++) begin
      tests++;
      if ({busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c]} !== {exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c]} ||
          (exp_chk[c] && sout_tr[c] !== exp_sout[c])) begin
        fails++; $display("FAIL single c=%0d got bdcps=%b%b%b%b%b exp=%b%b%b%b%b", c,
          busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c], sout_tr[c],
          exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c], exp_sout[c]);
      end
      if (clk_tr[c] && (c == 1 || !clk_tr[c-1])) begin rises++; bits = {bits[W-2:0], sout_tr[c]}; end
    end
    tests++;
    if (rises != W) begin fails++; $display("FAIL single_rises got=%0d exp=%0d", rises, W); end
    tests++;
    if (bits !== d) begin fails++; $display("FAIL single_bits got=%h exp=%h", bits, d); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    a = {$urandom, $urandom};
    b = 64'hFFFF_0000_FFFF_0000;
    model(a, 1, b);
    kick(a);
    observe(2 * T + 8, 100, b, 0, '0);
    for (int c = 1; c <= 2 * T + 8; c++) begin
      tests++;
      if ({busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c]} !== {exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c]} ||
          (exp_chk[c] && sout_tr[c] !== exp_sout[c])) begin
        fails++; $display("FAIL b2b c=%0d got bdcps=%b%b%b%b%b exp=%b%b%b%b%b", c,
          busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c], sout_tr[c],
          exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c], exp_sout[c]);
      end
    end
  endtask

  task automatic test_data_toggle();
    logic [W-1:0] a;
    a = {$urandom, $urandom};
    model(a, 0, '0);
    kick(a);
    observe(T + 6, 0, '0, 1, a);
    for (int c = 1; c <= T + 6; c++) begin
      tests++;
      if ({busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c]} !== {exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c]} ||
          (exp_chk[c] && sout_tr[c] !== exp_sout[c])) begin
        fails++; $display("FAIL toggle c=%0d got bdcps=%b%b%b%b%b exp=%b%b%b%b%b", c,
          busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c], sout_tr[c],
          exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c], exp_sout[c]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 8; it++) begin
      logic [W-1:0] a, b;
      int mid, n;
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, T)) : 0;
      n   = (mid != 0) ? 2 * T + 6 : T + 6;
      model(a, mid != 0, b);
      kick(a);
      observe(n, mid, b, 0, '0);
      for (int c = 1; c <= n; c++) begin
        tests++;
        if ({busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c]} !== {exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c]} ||
            (exp_chk[c] && sout_tr[c] !== exp_sout[c])) begin
          fails++; $display("FAIL random it=%0d mid=%0d c=%0d got bdcps=%b%b%b%b%b exp=%b%b%b%b%b", it, mid, c,
            busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c], sout_tr[c],
            exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c], exp_sout[c]);
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] a;
    a = {$urandom, $urandom};
    kick(a);
    observe(49, 20, ~a, 0, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, seg_clk, seg_sout, seg_pen, seg_clrn} !== 6'b0) begin
      fails++; $display("FAIL midreset_async got=%b exp=000000",
                        {busy, done, seg_clk, seg_sout, seg_pen, seg_clrn});
    end
`ifdef SEG_AUTO_REFRESH_EN
    data = '0;
`endif
    @(negedge clk);
    rst = 1'b1;
    observe(T + 10, 0, '0, 0, '0);
    for (int c = 1; c <= T + 10; c++) begin
      tests++;
      if (busy_tr[c] !== 1'b0 || clk_tr[c] !== 1'b0) begin
        fails++; $display("FAIL midreset_idle c=%0d busy=%b seg_clk=%b exp 0 0", c, busy_tr[c], clk_tr[c]);
      end
    end
  endtask

`ifdef SEG_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    model(64'h1234, 0, '0);
    @(negedge clk);
    data = 64'h1234;
    observe(T + 40, 0, '0, 0, '0);
    for (int c = 1; c <= T + 40; c++) begin
      tests++;
      if ({busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c]} !== {exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c]} ||
          (exp_chk[c] && sout_tr[c] !== exp_sout[c])) begin
        fails++; $display("FAIL auto c=%0d got bdcps=%b%b%b%b%b exp=%b%b%b%b%b", c,
          busy_tr[c], done_tr[c], clk_tr[c], pen_tr[c], sout_tr[c],
          exp_busy[c], exp_done[c], exp_clk[c], exp_pen[c], exp_sout[c]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SEG_AUTO_REFRESH_EN
    test_auto_refresh();
`endif
    test_single_frame();
    test_back_to_back();
    test_data_toggle();
    test_random_frames();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
